iot_feeder: RTL and testbench
=============================

IOT_FEEDER -- requirements
Module: iot_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 4: word-FIFO depth in 128-bit entries, power of two, 2..16.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port wr_valid, input, 1: upstream offers wr_data.
REQ-005 SHALL have port wr_data, input, 128: IoT sample word; byte k = bits [8k+7:8k].
REQ-006 SHALL have port wr_ready, output, 1: FIFO can accept a word this cycle.
REQ-007 SHALL have port busy, input, 1: downstream IOTDF stall; sampled at the rising edge.
REQ-008 SHALL have port in_en, output, 1: iot_in carries a valid byte.
REQ-009 SHALL have port iot_in, output, 8: byte to IOTDF.
REQ-010 SHALL have port fifo_cnt, output, $clog2(DEPTH)+1: words held, excluding the word in flight.
REQ-011 SHALL have port words_sent, output, 8: count of fully transmitted words.

Function
REQ-012 SHALL accept a word on a rising edge with wr_valid=1 and wr_ready=1.
REQ-013 SHALL drive wr_ready = (fifo_cnt < DEPTH) combinationally from registered count only.
REQ-014 SHALL register in_en and iot_in: no combinational path from busy or wr_* to outputs.
REQ-015 SHALL use the FSM states IDLE (no word in flight) and SEND (word loaded into a 128-bit shift/hold register, byte_idx 0..15).
REQ-016 SHALL transition IDLE->SEND on an edge where fifo_cnt>0: pop the head into the hold register with byte_idx=0; in_en stays 0 this cycle.
REQ-017 SHALL, in SEND on an edge with busy=0, set in_en<=1 and iot_in<=byte[byte_idx], then increment byte_idx.
REQ-018 SHALL, in SEND on an edge with busy=1, set in_en<=0 and iot_in<=8'h00, and hold byte_idx.
REQ-019 SHALL send bytes LSB-first: byte 0 (bits 7:0) first, byte 15 (bits 127:120) last.
REQ-020 SHALL, on the edge that issues byte 15, increment words_sent (wrapping 255->0).
REQ-021 SHALL, on that same byte-15 edge, pop the next word if fifo_cnt>0, so byte 0 of the next word follows on the next non-busy edge with no gap; otherwise go to IDLE.
REQ-022 SHALL drive in_en<=0 and iot_in<=8'h00 in IDLE.
REQ-023 SHALL, on a simultaneous push and pop, leave fifo_cnt unchanged; a slot freed by a pop is visible on wr_ready only in the next cycle.
REQ-024 SHALL wrap FIFO read and write pointers modulo DEPTH; writes are ignored when full.
REQ-025 SHALL keep stream order equal to accept order.

Reset
REQ-026 SHALL, on rst=0 at any time including mid-word, immediately set: state IDLE, byte_idx 0, pointers 0, fifo_cnt 0, words_sent 0, in_en 0, iot_in 8'h00, wr_ready 1.
REQ-027 SHALL discard the partially sent word on reset and SHALL NOT resume it.
REQ-028 SHALL leave FIFO data storage unreset.

Structure
REQ-029 SHALL place the constants BYTES_PER_WORD=16, WORD_W=128 and BYTE_W=8, and the state enum {IDLE,SEND}, in shared package iot_pkg.
REQ-030 SHALL instantiate the FIFO as sub-module iot_word_fifo (DEPTH param, push/pop/count); the FSM and serializer live in iot_feeder.

Verification
REQ-031 SHALL pass this scenario: push 128'h0F0E0D0C0B0A09080706050403020100 with busy=0 -> in_en high 16 consecutive cycles, iot_in 00,01,...,0F, then words_sent=1.
REQ-032 SHALL pass this scenario: same word with busy=1 on the edges issuing bytes 4-6 -> in_en=0 for 3 cycles, stream resumes at 04, no byte lost or duplicated.
REQ-033 SHALL pass this scenario: push 5 words back-to-back with DEPTH=4 -> wr_ready drops after the FIFO is full; 5th word accepted once a pop occurs; 80 bytes emitted in order, words_sent=5.
REQ-034 SHALL pass this scenario: two words queued, busy=0 -> byte 0 of word 2 immediately follows byte 15 of word 1 with no idle cycle.
REQ-035 SHALL pass this scenario: rst=0 asserted after byte 7 -> in_en=0 and fifo_cnt=0 without waiting for a clock edge; words_sent=0; a new push restarts at byte 0.
REQ-036 SHALL pass this scenario: 256 words streamed -> words_sent wraps to 0.

Source files
------------

// File: rtl/iot_pkg.sv
// Shared constants and FSM state type for the IoT byte feeder.
package iot_pkg;
    localparam int BYTES_PER_WORD = 16;
    localparam int WORD_W         = 128;
    localparam int BYTE_W         = 8;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;
endpackage

// File: rtl/iot_word_fifo.sv
// Word FIFO holding 128-bit samples ahead of the byte serializer.
module iot_word_fifo
    import iot_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WORD_W-1:0]        wdata,
    output logic [WORD_W-1:0]        rdata,
    output logic [$clog2(DEPTH):0]   cnt,
    output logic                     ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic              do_push;
    logic              do_pop;

    assign ready   = (cnt < CW'(DEPTH));
    assign do_push = push && ready;
    assign do_pop  = pop && (cnt != '0);
    assign rdata   = mem[rptr];

    // Storage is data only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers are PW bits wide and DEPTH is a power of two, so they wrap on their own.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/iot_feeder.sv
// Buffers 128-bit words and streams them LSB-first, one byte per non-stalled cycle, to the IOTDF.
module iot_feeder
    import iot_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    input  logic [WORD_W-1:0]        wr_data,
    output logic                     wr_ready,
    input  logic                     busy,
    output logic                     in_en,
    output logic [BYTE_W-1:0]        iot_in,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic [7:0]               words_sent
);
    localparam int IDXW = $clog2(BYTES_PER_WORD);

    state_t            state;
    state_t            state_nxt;
    logic [IDXW-1:0]   byte_idx;
    logic [WORD_W-1:0] hold;
    logic [WORD_W-1:0] head;
    logic              pop;
    logic              issue;
    logic              last_byte;

    iot_word_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_valid),
        .pop   (pop),
        .wdata (wr_data),
        .rdata (head),
        .cnt   (fifo_cnt),
        .ready (wr_ready)
    );

    assign issue     = (state == SEND) && !busy;
    assign last_byte = issue && (byte_idx == IDXW'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Reloading on the last-byte edge keeps back-to-back words gapless.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_cnt != '0) begin
                    pop       = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (last_byte) begin
                    if (fifo_cnt != '0) begin
                        pop = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx   <= '0;
            in_en      <= 1'b0;
            iot_in     <= '0;
            words_sent <= '0;
        end else begin
            in_en  <= issue;
            iot_in <= issue ? hold[{byte_idx, 3'b000} +: BYTE_W] : '0;
            if (last_byte) begin
                words_sent <= words_sent + 1'b1;
            end
            if (pop) begin
                byte_idx <= '0;
            end else if (issue) begin
                byte_idx <= byte_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            hold <= head;
        end
    end
endmodule

// File: tb/tb_iot_feeder.sv
// Scoreboard bench: accepted words become expected byte streams, a monitor checks every emitted byte.
module tb_iot_feeder;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           wr_valid = 1'b0;
    logic [127:0]   wr_data = '0;
    logic           busy = 1'b0;
    logic           wr_ready;
    logic           in_en;
    logic [7:0]     iot_in;
    logic [CW-1:0]  fifo_cnt;
    logic [7:0]     words_sent;

    iot_feeder #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .busy       (busy),
        .in_en      (in_en),
        .iot_in     (iot_in),
        .fifo_cnt   (fifo_cnt),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];
    int         nbytes = 0;
    int         exp_ws = 0;
    logic       prev_busy = 1'b0;
    logic       rnd_done = 1'b0;

    localparam logic [127:0] W_SEQ = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] W_ALT = 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an accepted word is simply its 16 bytes, lowest byte first.
    always @(posedge clk) begin
        if (!rst) begin
            prev_busy <= 1'b0;
        end else begin
            prev_busy <= busy;
            if (wr_valid && wr_ready) begin
                for (int k = 0; k < 16; k++) begin
                    exp_q.push_back(wr_data[8*k +: 8]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            nbytes = 0;
            exp_ws = 0;
        end else begin
            if (in_en) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte: got %0h expected none", iot_in);
                end else begin
                    check("stream_byte", iot_in, exp_q.pop_front());
                    nbytes++;
                    if (nbytes % 16 == 0) exp_ws = (exp_ws + 1) % 256;
                end
            end else begin
                check("idle_iot_in", iot_in, 0);
            end
            if (prev_busy) check("busy_stall", in_en, 0);
            check("words_sent", words_sent, exp_ws);
            check("wr_ready_vs_cnt", wr_ready, (fifo_cnt < DEPTH));
        end
    end

    task automatic push_word(input logic [127:0] w);
        int n = 0;
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = w;
        while (!wr_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            total++;
            bad++;
            $display("FAIL push_timeout: got wr_ready=0 expected 1");
            wr_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 wr_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || in_en) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_time", (n < 6000), 1);
        @(negedge clk);
    endtask

    task automatic run_len(output int len);
        int n = 0;
        len = 0;
        @(negedge clk);
        while (!in_en && n < 200) begin
            @(negedge clk);
            n++;
        end
        while (in_en && len < 1000) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic wait_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!(in_en && iot_in == b) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("saw_byte", (n < 300), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
    endtask

    initial begin
        int len;
        #1;
        check("rst_in_en", in_en, 0);
        check("rst_iot_in", iot_in, 0);
        check("rst_fifo_cnt", fifo_cnt, 0);
        check("rst_words_sent", words_sent, 0);
        check("rst_wr_ready", wr_ready, 1);
        @(negedge clk);
        #2 rst = 1'b1;

        // Single word, no stall: 16 consecutive bytes.
        push_word(W_SEQ);
        run_len(len);
        check("single_run_len", len, 16);
        wait_drain();
        check("single_words_sent", words_sent, 1);

        // Stall on the edges that would issue bytes 4..6.
        push_word(W_SEQ);
        wait_byte(8'h03);
        busy = 1'b1;
        repeat (3) @(negedge clk);
        busy = 1'b0;
        @(negedge clk);
        check("resume_en", in_en, 1);
        check("resume_byte", iot_in, 8'h04);
        wait_drain();
        check("stall_words_sent", words_sent, 2);

        // Fill the FIFO behind a stalled word, then drain.
        busy = 1'b1;
        for (int i = 0; i < 5; i++) push_word({16{8'(8'h10 + i)}});
        @(negedge clk);
        check("full_wr_ready", wr_ready, 0);
        check("full_cnt", fifo_cnt, DEPTH);
        busy = 1'b0;
        push_word({16{8'h55}});
        wait_drain();
        check("fill_words_sent", words_sent, 8);

        // Two queued words stream without a gap.
        busy = 1'b1;
        push_word(W_SEQ);
        push_word(W_ALT);
        @(negedge clk);
        busy = 1'b0;
        run_len(len);
        check("b2b_run_len", len, 32);
        wait_drain();

        // Random words, random gaps, random stalls.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 6)) @(negedge clk);
                    push_word({$urandom, $urandom, $urandom, $urandom});
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    busy = ($urandom_range(0, 3) == 0);
                end
                busy = 1'b0;
            end
        join
        wait_drain();
        check("rand_words_sent", words_sent, 8'(10 + 40));

        // Reset mid-word with a second word queued.
        busy = 1'b1;
        push_word(W_SEQ);
        push_word(W_SEQ);
        busy = 1'b0;
        wait_byte(8'h07);
        #2 rst = 1'b0;
        #1;
        check("midrst_in_en", in_en, 0);
        check("midrst_iot_in", iot_in, 0);
        check("midrst_fifo_cnt", fifo_cnt, 0);
        check("midrst_words_sent", words_sent, 0);
        check("midrst_wr_ready", wr_ready, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", in_en, 0);
        push_word(W_ALT);
        wait_byte(8'hA0);
        wait_drain();
        check("post_rst_words_sent", words_sent, 1);

        // 256 words wrap the transmitted-word counter.
        do_reset();
        for (int i = 0; i < 256; i++) push_word({$urandom, $urandom, $urandom, 24'h0, 8'(i)});
        wait_drain();
        check("wrap_words_sent", words_sent, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
